// File: rtl/stream_packetizer.sv
// stream_packetizer: pops a non-FWFT FIFO into registered AXI-Stream packets.
// Define STREAM_PACKETIZER_SYNC_CHECK_EN to add DEADBEEF/CAFEBABE frame hunting before each packet.
module stream_packetizer #(
  parameter int WORDS_PER_FRAME   = 144,
  parameter int FRAMES_PER_PACKET = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  output logic        fifo_read_en,
  input  logic [31:0] fifo_read_data,
  input  logic        fifo_empty,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [31:0] packets_sent,
  output logic [31:0] resync_count,
  output logic        busy
);
  localparam logic [15:0] LAST_IDX = 16'(WORDS_PER_FRAME * FRAMES_PER_PACKET - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, HUNT_LOW = 2'd1, HUNT_HIGH = 2'd2, STREAM = 2'd3} state_t;
`ifdef STREAM_PACKETIZER_SYNC_CHECK_EN
  localparam logic [31:0] SYNC_LO = 32'hDEADBEEF;
  localparam logic [31:0] SYNC_HI = 32'hCAFEBABE;
  localparam state_t START = HUNT_LOW;
`else
  localparam state_t START = STREAM;
`endif
  state_t      r_state, w_next;
  logic [31:0] r_skid0, r_skid1, r_tdata, r_packets;
  logic [1:0]  r_cnt;
  logic        r_rd_vld, r_tvalid, r_tlast;
  logic [15:0] r_wcnt, w_idx;
  logic [31:0] w_head, w_l1, w_pend;
  logic        w_head_vld, w_hs, w_load, w_take, w_emit, w_hunt_take;
  // The skid head is the oldest buffered word, or the word returning from last cycle's pop.
  assign w_head_vld = r_cnt != 2'd0 || r_rd_vld;
  assign w_head     = r_cnt != 2'd0 ? r_skid0 : fifo_read_data;
  assign w_l1       = r_cnt == 2'd2 ? r_skid1 : fifo_read_data;
  assign w_hs       = r_tvalid && m_axis_tready;
  assign w_load     = r_state == STREAM && w_head_vld && (!r_tvalid || (m_axis_tready && !r_tlast));
  assign w_take     = w_load || w_hunt_take;
  assign w_idx      = r_wcnt + 16'(r_tvalid);
`ifdef STREAM_PACKETIZER_SYNC_CHECK_EN
  logic [31:0] r_pend, r_resync;
  // On lock the held DEADBEEF goes out first; CAFEBABE stays at the head and streams next.
  assign w_emit      = w_head_vld && r_state == HUNT_HIGH && w_head == SYNC_HI;
  assign w_hunt_take = w_head_vld && (r_state == HUNT_LOW || (r_state == HUNT_HIGH && w_head != SYNC_HI));
  assign w_pend       = r_pend;
  assign resync_count = r_resync;
  always_ff @(posedge clk)
    if (!rstn) begin
      r_pend   <= '0;
      r_resync <= '0;
    end else if (w_hunt_take) begin
      if (w_head == SYNC_LO) r_pend <= w_head;
      r_resync <= r_resync + 32'(r_state == HUNT_HIGH) + 32'(w_head != SYNC_LO);
    end
`else
  assign w_emit       = 1'b0;
  assign w_hunt_take  = 1'b0;
  assign w_pend       = '0;
  assign resync_count = '0;
`endif
  always_ff @(posedge clk)
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = enable ? START : IDLE;
`ifdef STREAM_PACKETIZER_SYNC_CHECK_EN
      HUNT_LOW:  if (w_head_vld && w_head == SYNC_LO) w_next = HUNT_HIGH;
      HUNT_HIGH: if (w_head_vld) w_next = w_head == SYNC_HI ? STREAM : w_head == SYNC_LO ? HUNT_HIGH : HUNT_LOW;
`endif
      STREAM:    if (w_hs && r_tlast) w_next = enable ? START : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    fifo_read_en = rstn && !fifo_empty && r_state != IDLE && (r_cnt + 2'(r_rd_vld) < 2'd2);
    busy         = r_state != IDLE;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      r_cnt    <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_cnt    <= r_cnt + 2'(r_rd_vld) - 2'(w_take);
      r_rd_vld <= fifo_read_en;
    end
  always_ff @(posedge clk) begin
    r_skid0 <= w_take ? w_l1 : w_head;
    r_skid1 <= w_take ? fifo_read_data : w_l1;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else if (w_load || w_emit) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_idx == LAST_IDX;
      r_tdata  <= w_emit ? w_pend : w_head;
    end else if (w_hs) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  always_ff @(posedge clk)
    if (!rstn) begin
      r_wcnt    <= '0;
      r_packets <= '0;
    end else if (w_hs) begin
      r_wcnt    <= r_tlast ? '0 : r_wcnt + 16'd1;
      r_packets <= r_packets + 32'(r_tlast);
    end
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign packets_sent  = r_packets;
endmodule

// File: tb/tb_stream_packetizer.sv
// tb_stream_packetizer: scenario table plus reset and multi-frame sequences for stream_packetizer,
// with a frame-level reference model that follows the build's sync-check setting.
module tb_stream_packetizer;
  localparam int N = 144;
`ifdef STREAM_PACKETIZER_SYNC_CHECK_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  localparam logic [31:0] LO = 32'hDEADBEEF;
  localparam logic [31:0] HI = 32'hCAFEBABE;
  logic clk = 0, rstn = 0, enable = 0, tready = 1;
  always #5 clk = ~clk;
  logic rd_en, empty, tvalid, tlast, busy;
  logic [31:0] rdata = 0, tdata, pk, rs;
  logic [31:0] mem [4096];
  int wr = 0, rd = 0, pop_err = 0;
  assign empty = wr == rd;
  always @(posedge clk)
    if (rd_en) begin
      if (wr == rd) pop_err++;
      else begin
        rdata <= mem[rd % 4096];
        rd <= rd + 1;
      end
    end
  stream_packetizer dut (.clk(clk), .rstn(rstn), .enable(enable), .fifo_read_en(rd_en),
    .fifo_read_data(rdata), .fifo_empty(empty), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .packets_sent(pk), .resync_count(rs), .busy(busy));
  logic rd_en2, empty2, tvalid2, tlast2, busy2;
  logic [31:0] rdata2 = 0, tdata2, pk2, rs2;
  logic [31:0] mem2 [16];
  int wr2 = 0, rd2 = 0;
  assign empty2 = wr2 == rd2;
  always @(posedge clk)
    if (rd_en2 && wr2 != rd2) begin
      rdata2 <= mem2[rd2 % 16];
      rd2 <= rd2 + 1;
    end
  stream_packetizer #(.WORDS_PER_FRAME(4), .FRAMES_PER_PACKET(2)) dut2 (.clk(clk), .rstn(rstn),
    .enable(enable), .fifo_read_en(rd_en2), .fifo_read_data(rdata2), .fifo_empty(empty2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(1'b1), .m_axis_tlast(tlast2),
    .packets_sent(pk2), .resync_count(rs2), .busy(busy2));
  logic [31:0] gd [8192];
  logic gl [8192];
  int gn = 0, gt = 0, stall_err = 0;
  logic st = 0, sl = 0;
  logic [31:0] sd = 0;
  always @(negedge clk) begin
    if (rstn && st && !(tvalid && tdata == sd && tlast == sl)) stall_err++;
    if (rstn && tvalid && tready) begin
      gd[gn % 8192] = tdata;
      gl[gn % 8192] = tlast;
      gn++;
      if (tlast) gt++;
    end
    st = rstn && tvalid && !tready;
    sd = tdata;
    sl = tlast;
  end
  logic [31:0] gd2 [16];
  logic gl2 [16];
  int gn2 = 0;
  always @(negedge clk)
    if (rstn && tvalid2) begin
      if (gn2 < 16) begin
        gd2[gn2] = tdata2;
        gl2[gn2] = tlast2;
      end
      gn2++;
    end
  int tr_mode = 0, ph = 0;
  always @(posedge clk) begin
    #1;
    tready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom_range(0, 1));
    ph++;
  end
  logic [31:0] words [$];
  logic [31:0] md [$];
  logic ml [$];
  int mres;
  // Expected stream: each packet starts at the first DEADBEEF,CAFEBABE pair (sync build) and
  // every word skipped to reach it counts as a resync; without sync the input is chunked as is.
  function automatic void model(input int limit);
    int i = 0, pkc = 0;
    md.delete();
    ml.delete();
    mres = 0;
    while (i < words.size() && (limit == 0 || pkc < limit)) begin
      int j;
      j = i;
      if (SYNC != 0) begin
        while (j + 1 < words.size() && !(words[j] == LO && words[j+1] == HI)) j++;
        if (j + 1 >= words.size()) break;
        mres += j - i;
      end
      for (int k = 0; k < N && j + k < words.size(); k++) begin
        md.push_back(words[j+k]);
        ml.push_back(k == N - 1);
      end
      i = j + N;
      pkc++;
    end
  endfunction
  int total = 0, bad = 0, cur = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL s%0d %s: got %0h expected %0h", cur, name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] w);
    mem[wr % 4096] = w;
    wr++;
    words.push_back(w);
  endtask
  task automatic push_frame();
    push(LO);
    push(HI);
    for (int k = 0; k < N - 2; k++) push($urandom);
  endtask
  task automatic check_stream(input int base);
    int nerr;
    nerr = 0;
    check("word_count", 64'(gn - base), 64'(md.size()));
    for (int k = 0; k < md.size() && k < gn - base; k++)
      if (gd[(base + k) % 8192] !== md[k] || gl[(base + k) % 8192] !== ml[k]) nerr++;
    check("data_order_tlast", 64'(nerr), 0);
  endtask
  typedef struct packed {
    logic [0:5][31:0] pre;
    int npre, frames, tr, drop, epk, eres;
  } vec_t;
  vec_t tbl [6];
  vec_t v;
  int base, tbase, se, pe, cyc, nerr;
  logic [31:0] exp2 [8];
  initial begin
    tbl[0] = '{pre: '0, npre: 0, frames: 1, tr: 0, drop: 0, epk: 1, eres: 0};
    tbl[1] = '{pre: {32'h11111111, 32'h22222222, 32'h33333333, LO, 32'h12345678, 32'h0},
               npre: 5, frames: 1, tr: 0, drop: 0, epk: 1, eres: 5};
    tbl[2] = '{pre: '0, npre: 0, frames: 2, tr: 1, drop: 0, epk: 2, eres: 0};
    tbl[3] = '{pre: {LO, 160'h0}, npre: 1, frames: 1, tr: 2, drop: 0, epk: 1, eres: 1};
    tbl[4] = '{pre: {32'h0, LO, LO, 96'h0}, npre: 3, frames: 2, tr: 2, drop: 0, epk: 2, eres: 3};
    tbl[5] = '{pre: '0, npre: 0, frames: 2, tr: 0, drop: 50, epk: 1, eres: 0};
    exp2 = '{LO, HI, 32'd1, 32'd2, LO, HI, 32'd3, 32'd4};
    for (int s = 0; s < 6; s++) begin
      cur = s;
      v = tbl[s];
      rstn = 0;
      enable = 0;
      tr_mode = v.tr;
      tick();
      tick();
      wr = rd;
      words.delete();
      for (int k = 0; k < v.npre; k++) push(v.pre[k]);
      for (int f = 0; f < v.frames; f++) push_frame();
      model(v.drop != 0 ? v.epk : 0);
      if (s == 0) begin
        for (int k = 0; k < 8; k++) mem2[k] = exp2[k];
        wr2 = 8;
      end
      se = stall_err;
      pe = pop_err;
      rstn = 1;
      tick();
      check("idle_after_reset", {tvalid, tlast, busy, rd_en, tdata}, 0);
      check("counters_after_reset", {pk, rs}, 0);
      enable = 1;
      base = gn;
      tbase = gt;
      cyc = 0;
      while (gt - tbase < v.epk && cyc < 4000) begin
        tick();
        cyc++;
        if (v.drop != 0 && gn - base >= v.drop) enable = 0;
      end
      check("packets_completed", 64'(gt - tbase), 64'(v.epk));
      repeat (30) tick();
      check("packets_sent", pk, 64'(v.epk));
      check("resync_count", rs, 64'(v.eres * SYNC));
      check("model_resync", rs, 64'(mres));
      check_stream(base);
      check("stall_stable", 64'(stall_err - se), 0);
      check("pop_while_empty", 64'(pop_err - pe), 0);
      if (v.drop != 0) begin
        check("idle_after_drop", {busy, rd_en}, 0);
        check("words_left_in_fifo", 64'(wr - rd > 0), 1);
      end
      if (s == 0) begin
        nerr = 0;
        for (int k = 0; k < 8; k++) if (gd2[k] !== exp2[k] || gl2[k] !== (k == 7)) nerr++;
        check("mf_word_count", 64'(gn2), 8);
        check("mf_data_tlast", 64'(nerr), 0);
        check("mf_packets_sent", pk2, 1);
      end
    end
    cur = 6;
    rstn = 0;
    enable = 1;
    tr_mode = 0;
    tick();
    tick();
    wr = rd;
    words.delete();
    push_frame();
    push_frame();
    rstn = 1;
    base = gn;
    tbase = gt;
    for (int c = 0; c < 2000 && gn - base < 70; c++) tick();
    check("reached_word70", 64'(gn - base >= 70), 1);
    rstn = 0;
    tick();
    check("reset_mid_outputs", {tvalid, tlast, busy, rd_en, tdata}, 0);
    check("reset_mid_counters", {pk, rs}, 0);
    check("no_tlast_before_reset", 64'(gt - tbase), 0);
    wr = rd;
    words.delete();
    push_frame();
    model(0);
    tick();
    rstn = 1;
    base = gn;
    tbase = gt;
    for (int c = 0; c < 2000 && gt - tbase < 1; c++) tick();
    repeat (30) tick();
    check("restart_first_word", gd[base % 8192], LO);
    check("restart_packets", pk, 1);
    check("restart_resync", rs, 64'(mres));
    check_stream(base);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
